// File: rtl/data_memory_unit.sv
// ---------------------------------------------------------------------------
// data_memory_unit
//
// Byte-addressable data memory for the datapath. Supports byte/half/word
// stores through byte-lane enables, sign- or zero-extended sub-word loads,
// a registered read path with 1 or 2 cycles of latency, and request fault
// detection (misaligned, out of range, illegal).
//
// Parameters:
//   BASE_ADDR     byte address of word 0
//   DEPTH_WORDS   number of 32-bit words (power of two, 16..65536)
//   READ_LATENCY  1 or 2 cycles from request edge to response
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   memory_read    load request this cycle
//   memory_write   store request this cycle
//   access_size    00 byte, 01 half, 10 word, 11 illegal
//   load_unsigned  1 = zero-extend sub-word loads, 0 = sign-extend
//   address        byte address
//   write_data     store data, right-justified for byte/half
//   read_data      load result, 0 unless read_valid
//   read_valid     one-cycle strobe per load request
//   fault          one-cycle strobe per faulted request
//   fault_code     01 misaligned, 10 out of range, 11 illegal, 00 otherwise
// ---------------------------------------------------------------------------
module data_memory_unit #(
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
    parameter int unsigned DEPTH_WORDS  = 4096,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic [1:0]  access_size,
    input  logic        load_unsigned,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic        fault,
    output logic [1:0]  fault_code
);

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        FC_NONE       = 2'b00,
        FC_MISALIGNED = 2'b01,
        FC_RANGE      = 2'b10,
        FC_ILLEGAL    = 2'b11
    } fault_e;

    localparam int unsigned AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS) << 2;

    // -----------------------------------------------------------------------
    // Address decode and fault classification
    // -----------------------------------------------------------------------
    logic [31:0]   offset;
    logic [AW-1:0] word_index;
    logic          in_range;
    logic          req;
    size_e         req_size;
    fault_e        req_code;
    logic          req_fault;

    // Modular subtraction: addresses below BASE_ADDR wrap to huge offsets
    // and therefore fail the range compare.
    assign offset     = address - BASE_ADDR;
    assign word_index = offset[AW+1:2];
    assign in_range   = (offset < SPAN_BYTES);
    assign req        = memory_read | memory_write;
    assign req_size   = size_e'(access_size);

    // NOTE: every signal driven in an always_comb gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        req_code = FC_NONE;
        if (req) begin
            if (req_size == SIZE_ILLEGAL || (memory_read && memory_write)) begin
                req_code = FC_ILLEGAL;
            end else if ((req_size == SIZE_HALF && address[0]) ||
                         (req_size == SIZE_WORD && address[1:0] != 2'b00)) begin
                req_code = FC_MISALIGNED;
            end else if (!in_range) begin
                req_code = FC_RANGE;
            end
        end
    end

    assign req_fault = (req_code != FC_NONE);

    // -----------------------------------------------------------------------
    // Store lane steering
    // -----------------------------------------------------------------------
    logic [3:0]      lane_en;
    logic [3:0][7:0] lane_data;
    logic            store_en;

    always_comb begin
        lane_en   = 4'b0000;
        lane_data = write_data;
        case (req_size)
            SIZE_BYTE: begin
                lane_en   = 4'b0001 << address[1:0];
                lane_data = {4{write_data[7:0]}};
            end
            SIZE_HALF: begin
                lane_en   = address[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{write_data[15:0]}};
            end
            SIZE_WORD: lane_en = 4'b1111;
            default:   lane_en = 4'b0000;
        endcase
    end

    // Requests presented while reset is high are ignored, stores included.
    assign store_en = memory_write & ~req_fault & ~reset;

    // -----------------------------------------------------------------------
    // Storage array and raw read register
    // -----------------------------------------------------------------------
    logic [3:0][7:0] mem_q [DEPTH_WORDS];
    logic [3:0][7:0] rd_word_q;

    // NOTE: the array and its read register carry no reset; contents are
    // undefined at power-up and a reset branch would prevent RAM inference.
    // Outputs are qualified by the reset-cleared valid flags instead.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (lane_en[lane]) begin
                    mem_q[word_index][lane] <= lane_data[lane];
                end
            end
        end
        if (memory_read && !reset) begin
            rd_word_q <= mem_q[word_index];
        end
    end

    // -----------------------------------------------------------------------
    // Response stage 1: request attributes captured alongside the read
    // -----------------------------------------------------------------------
    logic       s1_valid_q;
    logic       s1_fault_q;
    fault_e     s1_code_q;
    size_e      s1_size_q;
    logic [1:0] s1_lane_q;
    logic       s1_unsigned_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q    <= 1'b0;
            s1_fault_q    <= 1'b0;
            s1_code_q     <= FC_NONE;
            s1_size_q     <= SIZE_BYTE;
            s1_lane_q     <= 2'b00;
            s1_unsigned_q <= 1'b0;
        end else begin
            s1_valid_q    <= memory_read;
            s1_fault_q    <= req_fault;
            s1_code_q     <= req_code;
            s1_size_q     <= req_size;
            s1_lane_q     <= address[1:0];
            s1_unsigned_q <= load_unsigned;
        end
    end

    // Lane select and extension; a faulted load or no load yields zero.
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] s1_data;

    always_comb begin
        sel_byte = rd_word_q[s1_lane_q];
        sel_half = s1_lane_q[1] ? {rd_word_q[3], rd_word_q[2]}
                                : {rd_word_q[1], rd_word_q[0]};
        s1_data  = '0;
        if (s1_valid_q && !s1_fault_q) begin
            case (s1_size_q)
                SIZE_BYTE: s1_data = s1_unsigned_q ? {24'b0, sel_byte}
                                                   : {{24{sel_byte[7]}}, sel_byte};
                SIZE_HALF: s1_data = s1_unsigned_q ? {16'b0, sel_half}
                                                   : {{16{sel_half[15]}}, sel_half};
                SIZE_WORD: s1_data = rd_word_q;
                default:   s1_data = '0;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Optional second output register stage
    // -----------------------------------------------------------------------
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [31:0] out_data_q;
            logic        out_valid_q;
            logic        out_fault_q;
            logic [1:0]  out_code_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    out_data_q  <= '0;
                    out_valid_q <= 1'b0;
                    out_fault_q <= 1'b0;
                    out_code_q  <= FC_NONE;
                end else begin
                    out_data_q  <= s1_data;
                    out_valid_q <= s1_valid_q;
                    out_fault_q <= s1_fault_q;
                    out_code_q  <= s1_code_q;
                end
            end

            assign read_data  = out_data_q;
            assign read_valid = out_valid_q;
            assign fault      = out_fault_q;
            assign fault_code = out_code_q;
        end else begin : g_lat1
            assign read_data  = s1_data;
            assign read_valid = s1_valid_q;
            assign fault      = s1_fault_q;
            assign fault_code = s1_code_q;
        end
    endgenerate

endmodule

// File: tb/tb_data_memory_unit.sv
// ---------------------------------------------------------------------------
// tb_data_memory_unit
//
// Drives identical traffic into a READ_LATENCY=1 and a READ_LATENCY=2
// instance. Each request pushes its expected response onto a per-instance
// queue tagged with the cycle it is due; a negedge monitor pops and compares
// due entries and requires all-zero outputs on every other cycle.
// ---------------------------------------------------------------------------
module tb_data_memory_unit;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 64;
    localparam logic [31:0] SPAN  = DEPTH * 4;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef struct {
        int          due;
        logic        valid;
        logic [31:0] data;
        logic        fault;
        logic [1:0]  code;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memory_read = 1'b0;
    logic        memory_write = 1'b0;
    logic [1:0]  access_size = 2'b00;
    logic        load_unsigned = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;

    logic [31:0] rd1, rd2;
    logic        rv1, rv2, f1, f2;
    logic [1:0]  fc1, fc2;

    int    cyc = 0;
    int    n_cmp = 0;
    int    n_err = 0;
    resp_t q1[$];
    resp_t q2[$];
    logic [31:0] mm [DEPTH];

    data_memory_unit #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .READ_LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset), .memory_read(memory_read), .memory_write(memory_write),
        .access_size(access_size), .load_unsigned(load_unsigned), .address(address),
        .write_data(write_data), .read_data(rd1), .read_valid(rv1), .fault(f1),
        .fault_code(fc1)
    );

    data_memory_unit #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .READ_LATENCY(2)) u_dut_l2 (
        .clk(clk), .reset(reset), .memory_read(memory_read), .memory_write(memory_write),
        .access_size(access_size), .load_unsigned(load_unsigned), .address(address),
        .write_data(write_data), .read_data(rd2), .read_valid(rv2), .fault(f2),
        .fault_code(fc2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic check_resp(input string tag, input logic [31:0] d, input logic v,
                              input logic f, input logic [1:0] c, input resp_t e);
        check({tag, ".read_data"},  d,             e.data);
        check({tag, ".read_valid"}, {31'b0, v},    {31'b0, e.valid});
        check({tag, ".fault"},      {31'b0, f},    {31'b0, e.fault});
        check({tag, ".fault_code"}, {30'b0, c},    {30'b0, e.code});
    endtask

    // Monitor: outputs sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        resp_t e1, e2;
        e1 = '{default: 0};
        e2 = '{default: 0};
        if (reset) begin
            q1.delete();
            q2.delete();
        end else begin
            if (q1.size() != 0 && q1[0].due == cyc) e1 = q1.pop_front();
            if (q2.size() != 0 && q2[0].due == cyc) e2 = q2.pop_front();
        end
        check_resp("lat1", rd1, rv1, f1, fc1, e1);
        check_resp("lat2", rd2, rv2, f2, fc2, e2);
    end

    // ---------------- reference model ----------------
    function automatic logic [1:0] exp_code(input logic rd, input logic wr,
                                            input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (sz == SZ_X || (rd && wr)) return 2'b11;
        if ((sz == SZ_H && a[0]) || (sz == SZ_W && a[1:0] != 2'b00)) return 2'b01;
        if (off >= SPAN) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off >> 2) % DEPTH;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                               input logic [31:0] a);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = mm[widx(a)];
        b = w[8*a[1:0] +: 8];
        h = w[16*a[1] +: 16];
        case (sz)
            SZ_B:    return uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_H:    return uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w;
        w = mm[widx(a)];
        case (sz)
            SZ_B:    w[8*a[1:0] +: 8] = d[7:0];
            SZ_H:    w[16*a[1] +: 16] = d[15:0];
            default: w = d;
        endcase
        mm[widx(a)] = w;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic use_exp, input logic [31:0] exp_data);
        resp_t      e;
        logic [1:0] code;
        @(negedge clk);
        memory_read   = rd;
        memory_write  = wr;
        access_size   = sz;
        load_unsigned = uns;
        address       = a;
        write_data    = d;
        code = exp_code(rd, wr, sz, a);
        if (rd || code != 2'b00) begin
            e.valid = rd;
            e.fault = (code != 2'b00);
            e.code  = code;
            e.data  = (rd && code == 2'b00) ? (use_exp ? exp_data : model_load(sz, uns, a)) : '0;
            e.due   = cyc + 1;
            q1.push_back(e);
            e.due   = cyc + 2;
            q2.push_back(e);
        end
        if (wr && !rd && code == 2'b00) model_store(sz, a, d);
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        issue(1'b0, 1'b1, sz, 1'b0, a, d, 1'b0, '0);
    endtask

    task automatic load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        issue(1'b1, 1'b0, sz, uns, a, '0, 1'b0, '0);
    endtask

    task automatic load_exp(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                            input logic [31:0] exp_data);
        issue(1'b1, 1'b0, sz, uns, a, '0, 1'b1, exp_data);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            memory_read  = 1'b0;
            memory_write = 1'b0;
            access_size  = SZ_B;
            address      = '0;
            write_data   = '0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        // Held in reset for a few cycles; monitor requires all-zero outputs.
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;

        // Fill memory with known contents.
        for (int i = 0; i < DEPTH; i++) store(SZ_W, BASE + 32'(4 * i), 32'h8040_2010 + 32'(i) * 32'h0103_0507);
        idle(2);

        // Word store then word load.
        store(SZ_W, BASE + 8, 32'hDEAD_BEEF);
        load_exp(SZ_W, 1'b0, BASE + 8, 32'hDEAD_BEEF);
        idle(3);

        // Byte store over a zero word, signed/unsigned byte and word reads.
        store(SZ_W, BASE + 8, 32'h0000_0000);
        store(SZ_B, BASE + 9, 32'h0000_0080);
        load_exp(SZ_B, 1'b0, BASE + 9, 32'hFFFF_FF80);
        load_exp(SZ_B, 1'b1, BASE + 9, 32'h0000_0080);
        load_exp(SZ_W, 1'b1, BASE + 8, 32'h0000_8000);
        idle(2);

        // Half store into upper half, lower half preserved.
        store(SZ_W, BASE, 32'h1122_3344);
        store(SZ_H, BASE + 2, 32'h0000_A5A5);
        load_exp(SZ_W, 1'b0, BASE, 32'hA5A5_3344);
        idle(2);

        // Half-word and byte-lane extension.
        store(SZ_W, BASE + 24, 32'h8001_7FFE);
        load_exp(SZ_H, 1'b0, BASE + 24, 32'h0000_7FFE);
        load_exp(SZ_H, 1'b0, BASE + 26, 32'hFFFF_8001);
        load_exp(SZ_H, 1'b1, BASE + 26, 32'h0000_8001);
        load_exp(SZ_B, 1'b0, BASE + 24, 32'hFFFF_FFFE);
        load_exp(SZ_B, 1'b0, BASE + 25, 32'h0000_007F);
        load_exp(SZ_B, 1'b1, BASE + 27, 32'h0000_0080);
        idle(2);

        // Faults.
        load(SZ_W, 1'b0, BASE + 6);                         // misaligned load
        load(SZ_H, 1'b1, BASE + 1);                         // misaligned half
        store(SZ_W, BASE + SPAN, 32'hFFFF_FFFF);            // out of range (aliases word 0)
        load_exp(SZ_W, 1'b0, BASE, 32'hA5A5_3344);
        store(SZ_W, BASE - 4, 32'h1234_5678);               // below base (aliases last word)
        load(SZ_W, 1'b0, BASE + SPAN - 4);
        issue(1'b1, 1'b1, SZ_W, 1'b0, BASE + 16, 32'h0BAD_F00D, 1'b0, '0);  // both high
        load(SZ_W, 1'b0, BASE + 16);
        store(SZ_X, BASE + 20, 32'h0BAD_F00D);              // illegal size store
        load(SZ_X, 1'b0, BASE + 20);                        // illegal size load
        load(SZ_W, 1'b0, BASE + 20);
        store(SZ_W, BASE + 9, 32'hFFFF_FFFF);               // misaligned store, no change
        load_exp(SZ_W, 1'b0, BASE + 8, 32'h0000_8000);
        load(SZ_W, 1'b0, BASE + SPAN + 2);                  // misaligned beats out of range
        store(SZ_X, BASE - 1, 32'h0);                       // illegal beats everything
        load_exp(SZ_B, 1'b0, BASE + SPAN - 1, 32'h0000_0000 | model_load(SZ_B, 1'b0, BASE + SPAN - 1));
        idle(3);

        // Store followed by a same-word load on the next cycle.
        store(SZ_W, BASE + 120, 32'hCAFE_F00D);
        load_exp(SZ_W, 1'b0, BASE + 120, 32'hCAFE_F00D);

        // Back-to-back loads to distinct words.
        for (int i = 0; i < 8; i++) load(SZ_W, 1'b0, BASE + 32'(4 * (40 + i)));
        idle(4);

        // Reset one cycle after a load; store during reset is dropped.
        load(SZ_W, 1'b0, BASE + 8);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        memory_read  = 1'b0;
        memory_write = 1'b1;
        access_size  = SZ_W;
        address      = BASE + 12;
        write_data   = 32'hBAD0_BAD0;
        idle(2);
        #2 reset = 1'b0;
        idle(4);
        load(SZ_W, 1'b0, BASE + 12);
        idle(4);

        check("queue_lat1_drained", 32'(q1.size()), 32'd0);
        check("queue_lat2_drained", 32'(q2.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
